// File: rtl/cap_touch_scanner.sv
// Capacitive pad scanner: discharges/charges the shared line, times each pad's
// rise, then debounces the readings into touch state and sticky hit events.
module cap_touch_scanner #(
    parameter int unsigned NUM_PADS         = 9,
    parameter int unsigned CNT_W            = 16,
    parameter int unsigned DISCHARGE_CYCLES = 200,
    parameter int unsigned TIMEOUT_CYCLES   = 4000,
    parameter int unsigned DEBOUNCE_SCANS   = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CNT_W-1:0]    threshold,
    input  logic [NUM_PADS-1:0] capacitive_sensors_in,
    output logic                capacitive_sensors_out,
    output logic [NUM_PADS-1:0] touch_state,
    output logic [NUM_PADS-1:0] touch_event,
    input  logic [NUM_PADS-1:0] event_clear,
    output logic                scan_done,
    input  logic [3:0]          debug_sel,
    output logic [CNT_W-1:0]    debug_count
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISCHARGE,
        ST_CHARGE,
        ST_EVAL
    } state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_PADS-1:0] sync1, sync2;
    logic [NUM_PADS-1:0] captured, cap_now;
    logic [CNT_W-1:0]    rise_work [NUM_PADS];
    logic [CNT_W-1:0]    rise_pub  [NUM_PADS];
    logic [DBW-1:0]      db_cnt    [NUM_PADS];
    logic [DBW-1:0]      db_next   [NUM_PADS];
    logic [NUM_PADS-1:0] raw, ts_next, ev_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= capacitive_sensors_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        cap_now    = sync2 & ~captured;
        case (state)
            ST_IDLE:      if (enable) next_state = ST_DISCHARGE;
            ST_DISCHARGE: if (cnt == CNT_W'(DISCHARGE_CYCLES - 1)) next_state = ST_CHARGE;
            ST_CHARGE: begin
                if (((captured | cap_now) == '1) || (cnt == CNT_W'(TIMEOUT_CYCLES - 1)))
                    next_state = ST_EVAL;
            end
            ST_EVAL:      next_state = enable ? ST_DISCHARGE : ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // Charge line is registered off next_state so it is glitch-free and high
    // exactly for the CHARGE cycles.
    always_ff @(posedge clock) begin
        if (reset) capacitive_sensors_out <= 1'b0;
        else       capacitive_sensors_out <= (next_state == ST_CHARGE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            captured <= '0;
            for (int unsigned i = 0; i < NUM_PADS; i++) rise_work[i] <= '0;
        end else begin
            case (state)
                ST_DISCHARGE: begin
                    captured <= '0;
                    cnt      <= (next_state == ST_CHARGE) ? '0 : cnt + 1'b1;
                end
                ST_CHARGE: begin
                    cnt      <= cnt + 1'b1;
                    captured <= captured | cap_now;
                    for (int unsigned i = 0; i < NUM_PADS; i++) begin
                        if (cap_now[i])
                            rise_work[i] <= cnt;
                        else if (!captured[i] && next_state == ST_EVAL)
                            rise_work[i] <= CNT_W'(TIMEOUT_CYCLES);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_PADS; i++) raw[i] = (rise_work[i] >= threshold);
    end

    always_comb begin
        ts_next = touch_state;
        ev_set  = '0;
        for (int unsigned i = 0; i < NUM_PADS; i++) begin
            db_next[i] = db_cnt[i];
            if (state == ST_EVAL) begin
                if (raw[i] == touch_state[i]) begin
                    db_next[i] = '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_SCANS - 1)) begin
                    ts_next[i] = raw[i];
                    db_next[i] = '0;
                    ev_set[i]  = raw[i];
                end else begin
                    db_next[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            touch_state <= '0;
            touch_event <= '0;
            scan_done   <= 1'b0;
            for (int unsigned i = 0; i < NUM_PADS; i++) begin
                db_cnt[i]   <= '0;
                rise_pub[i] <= '0;
            end
        end else begin
            touch_state <= ts_next;
            touch_event <= (touch_event & ~event_clear) | ev_set;
            scan_done   <= (state == ST_EVAL);
            for (int unsigned i = 0; i < NUM_PADS; i++) begin
                db_cnt[i] <= db_next[i];
                if (state == ST_EVAL) rise_pub[i] <= rise_work[i];
            end
        end
    end

    always_comb begin
        debug_count = '0;
        if (32'(debug_sel) < NUM_PADS) debug_count = rise_pub[debug_sel];
    end

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Directed bench for cap_touch_scanner: a pad model rises each pad a set
// number of cycles after the charge line goes high.
module tb_cap_touch_scanner;

    localparam int NP    = 9;
    localparam int NEVER = 10000;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [15:0]   threshold;
    logic [NP-1:0] pads;
    logic          out;
    logic [NP-1:0] touch_state;
    logic [NP-1:0] touch_event;
    logic [NP-1:0] event_clear;
    logic          scan_done;
    logic [3:0]    debug_sel;
    logic [15:0]   debug_count;

    int dly [NP];
    int age;
    int checks   = 0;
    int failures = 0;
    int cyc, hi, n, busy;

    cap_touch_scanner #(
        .NUM_PADS(9), .CNT_W(16), .DISCHARGE_CYCLES(4),
        .TIMEOUT_CYCLES(64), .DEBOUNCE_SCANS(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .threshold(threshold),
        .capacitive_sensors_in(pads), .capacitive_sensors_out(out),
        .touch_state(touch_state), .touch_event(touch_event),
        .event_clear(event_clear), .scan_done(scan_done),
        .debug_sel(debug_sel), .debug_count(debug_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pad i goes high on the edge dly[i] cycles after the charge line rose.
    initial begin
        age  = 0;
        pads = '0;
        forever begin
            @(posedge clock);
            #1;
            age = out ? age + 1 : 0;
            for (int i = 0; i < NP; i++) pads[i] = out && (age > dly[i]);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_scan(input int d3, input int d8, input logic [NP-1:0] clr_eval,
                            input bit drop_en, output int c, output int h);
        logic prev_out;
        bit   done;
        for (int i = 0; i < NP; i++) dly[i] = 5;
        dly[3] = d3;
        dly[8] = d8;
        c = 0; h = 0; done = 0;
        prev_out = out;
        while (!done && c < 300) begin
            @(negedge clock);
            c++;
            if (out) h++;
            event_clear = (prev_out && !out) ? clr_eval : '0;
            if (drop_en && out) enable = 1'b0;
            prev_out = out;
            if (scan_done) done = 1;
        end
        event_clear = '0;
        if (!done) check_val("scan_timeout", 0, 1);
    endtask

    task automatic pulse_clear(input logic [NP-1:0] m);
        @(negedge clock);
        event_clear = m;
        @(negedge clock);
        event_clear = '0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; threshold = 16'd20;
        event_clear = '0; debug_sel = 4'd0;
        for (int i = 0; i < NP; i++) dly[i] = 5;
        repeat (3) @(negedge clock);
        check_val("rst_out", out, 0);
        check_val("rst_state", touch_state, 0);
        check_val("rst_event", touch_event, 0);
        check_val("rst_done", scan_done, 0);
        check_val("rst_dbg", debug_count, 0);
        reset = 1'b0;
        @(negedge clock);
        enable = 1'b1;

        // all pads fast
        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("a_charge_len", hi, 8);
        check_val("a_state", touch_state, 0);
        for (int i = 0; i < NP; i++) begin
            debug_sel = 4'(i);
            #1 check_val("a_dbg_rise", debug_count, 7);
        end
        debug_sel = 4'd9;
        #1 check_val("dbg_oob9", debug_count, 0);
        debug_sel = 4'd15;
        #1 check_val("dbg_oob15", debug_count, 0);
        @(negedge clock);
        check_val("done_width", scan_done, 0);

        // pad 3 slow
        debug_sel = 4'd3;
        run_scan(30, 5, '0, 0, cyc, hi);
        check_val("b_state_1scan", touch_state, 0);
        check_val("b_dbg3", debug_count, 32);
        run_scan(30, 5, '0, 0, cyc, hi);
        check_val("c_state", touch_state, 9'h008);
        check_val("c_event", touch_event, 9'h008);

        // pad 8 never rises
        debug_sel = 4'd8;
        run_scan(30, NEVER, '0, 0, cyc, hi);
        check_val("d_charge_len", hi, 64);
        check_val("d_dbg8", debug_count, 64);
        check_val("d_state", touch_state, 9'h008);
        run_scan(30, NEVER, '0, 0, cyc, hi);
        check_val("e_state", touch_state, 9'h108);
        check_val("e_event", touch_event, 9'h108);

        pulse_clear(9'h100);
        check_val("clr_bit8", touch_event, 9'h008);

        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("f_charge_len", hi, 8);
        check_val("f_state", touch_state, 9'h108);
        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("g_period", cyc, 13);
        check_val("g_state", touch_state, 0);
        pulse_clear(9'h008);
        check_val("clr_bit3", touch_event, 0);

        // clear coincides with the 0->1 edge of pad 3
        run_scan(30, 5, '0, 0, cyc, hi);
        check_val("h_state", touch_state, 0);
        run_scan(30, 5, 9'h008, 0, cyc, hi);
        check_val("i_state", touch_state, 9'h008);
        check_val("i_set_wins", touch_event, 9'h008);

        // debounce: slow, fast, slow, slow after returning to untouched
        run_scan(5, 5, '0, 0, cyc, hi);
        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("k_state", touch_state, 0);
        run_scan(30, 5, '0, 0, cyc, hi);
        check_val("l_state", touch_state, 0);
        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("m_state", touch_state, 0);
        run_scan(30, 5, '0, 0, cyc, hi);
        check_val("n_state", touch_state, 0);
        run_scan(30, 5, '0, 0, cyc, hi);
        check_val("o_state", touch_state, 9'h008);

        // enable dropped mid-charge
        run_scan(5, 5, '0, 1, cyc, hi);
        check_val("drop_state", touch_state, 9'h008);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out || scan_done) busy++;
        end
        check_val("idle_quiet", busy, 0);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out && n < 50);
        check_val("restart_lat", n, 5);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        debug_sel = 4'd0;
        @(negedge clock);
        check_val("midrst_out", out, 0);
        check_val("midrst_state", touch_state, 0);
        check_val("midrst_event", touch_event, 0);
        check_val("midrst_done", scan_done, 0);
        check_val("midrst_dbg", debug_count, 0);
        reset = 1'b0;

        // threshold boundary at the rise time itself
        threshold = 16'd7;
        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("t7_state1", touch_state, 0);
        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("t7_state2", touch_state, 9'h1FF);
        check_val("t7_event", touch_event, 9'h1FF);
        threshold = 16'd8;
        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("t8_state1", touch_state, 9'h1FF);
        run_scan(5, 5, '0, 0, cyc, hi);
        check_val("t8_state2", touch_state, 0);
        check_val("t8_event", touch_event, 9'h1FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cap_touch_scanner.md
Name: cap_touch_scanner

Overview:
- Reads the 9 capacitive pads of the whack-a-mole board; it is the input side that pairs with the processor-driven LED output path.
- Drives the shared charge line `capacitive_sensors_out` and times how long each pad in `capacitive_sensors_in` takes to rise. A touched pad rises slowly.
- Turns each rise time into a debounced touch state and a sticky per-pad "hit" event. The processor reads both through its memory-mapped I/O.

Parameters:
- NUM_PADS, 9, number of sensor pads.
- CNT_W, 16, width of the rise-time counter.
- DISCHARGE_CYCLES, 200, cycles the charge line is held low before each measurement.
- TIMEOUT_CYCLES, 4000, maximum length of the charge phase; rise times saturate at this value.
- DEBOUNCE_SCANS, 3, consecutive agreeing scans needed to change a pad's touch state.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when high, scans run back to back; when low, the block idles after finishing the current scan.
- threshold  in  CNT_W  rise time at or above which a pad counts as touched in the raw reading.
- capacitive_sensors_in  in  NUM_PADS  asynchronous pad inputs.
- capacitive_sensors_out  out  1  charge line (1 = charge, 0 = discharge).
- touch_state  out  NUM_PADS  debounced touch state per pad.
- touch_event  out  NUM_PADS  sticky flag per pad, set on each 0->1 of touch_state.
- event_clear  in  NUM_PADS  one-cycle write mask that clears the matching touch_event bits.
- scan_done  out  1  one-cycle pulse when the results of a scan become visible.
- debug_sel  in  4  selects which pad's last rise time appears on debug_count.
- debug_count  out  CNT_W  last captured rise time of pad debug_sel; 0 if debug_sel >= NUM_PADS.

Behaviour:
- Reset (synchronous, active-high, wins over every other input, including mid-scan):
  - FSM goes to IDLE.
  - capacitive_sensors_out, touch_state, touch_event and scan_done all go to 0.
  - Rise-time registers and debounce counters clear; sync flops clear.
- Input synchronisation: each pad passes through a 2-flop synchroniser. The 2-cycle delay is included in the measured counts and is not compensated.
- FSM states:
  - IDLE: out=0. Move to DISCHARGE when enable=1.
  - DISCHARGE: out=0 for exactly DISCHARGE_CYCLES cycles, then move to CHARGE.
  - CHARGE:
    - out=1 and the counter starts at 0 on the first CHARGE cycle, incrementing by 1 each cycle.
    - Pad i's rise time is captured as the counter value on the first cycle its synchronised input is 1. Each pad captures once per scan.
    - Leave for EVAL when every pad has captured, or when the counter reaches TIMEOUT_CYCLES-1.
    - Any pad not captured by then gets rise time TIMEOUT_CYCLES.
  - EVAL (1 cycle): out=0.
    - raw[i] = (rise[i] >= threshold), compared as unsigned.
    - Debounce, per pad:
      - If raw[i] equals touch_state[i], its debounce counter resets to 0.
      - Otherwise the counter increments. When it reaches DEBOUNCE_SCANS, touch_state[i] takes raw[i] and the counter resets.
    - Next state is DISCHARGE if enable=1, otherwise IDLE.
- Latency:
  - touch_state, debug_count and scan_done update on the clock edge that ends EVAL.
  - scan_done is high for exactly that following cycle.
  - Shortest possible scan: DISCHARGE_CYCLES + 1 + 1 cycles.
- enable:
  - Deasserting it mid-scan does not abort the scan; the scan completes and the FSM then enters IDLE.
  - Reasserting it in IDLE starts DISCHARGE on the next cycle.
- touch_event:
  - Bit i sets on the same edge that touch_state[i] goes 0->1.
  - event_clear[i] clears bit i.
  - If set and clear happen in the same cycle, set wins.
  - Bits for which event_clear is 0 are unaffected.
- Boundaries:
  - A pad already high on the first CHARGE cycle captures rise time 0 and reads untouched, unless threshold=0.
  - threshold=0 makes every pad read touched.
  - A threshold greater than TIMEOUT_CYCLES makes every pad read untouched.
  - The counter never wraps: CNT_W must hold TIMEOUT_CYCLES.
  - A pad's input dropping back to 0 after it has captured has no effect within that scan.

Test Plan:
Bench settings for all scenarios: DISCHARGE_CYCLES=4, TIMEOUT_CYCLES=64, DEBOUNCE_SCANS=2, threshold=20.
1. Reset, then enable=1, with every pad rising 5 cycles after out rises -> out low for 4 cycles then high, every rise time is 7, touch_state=0, scan_done pulses once per scan, debug_count=7.
2. Pad 3 rises 30 cycles after out rises, the others after 5 -> after 2 scans touch_state=9'h008 and touch_event=9'h008; after only 1 scan touch_state is still 0.
3. Pad 8 never rises -> its rise time is 64, the scan ends at counter 63, and touch_state[8]=1 after 2 scans.
4. With touch_event=9'h108, pulse event_clear=9'h100 -> touch_event=9'h008. Then make the clear coincide with a new 0->1 on pad 3 -> bit 3 stays set.
5. Pad 3 reads slow in one scan, fast in the next, then slow twice -> touch_state[3] stays 0 until the end of the 4th scan, then goes to 1.
6. Drop enable mid-CHARGE, then assert reset during a later scan -> the first scan completes with scan_done and the FSM idles with out=0; reset clears all outputs on the next edge.
